// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register indices, bit positions,
// reset/vector constants and the masked-write helper.
package cp0_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_IBE  = 5'd6,
    EXC_DBE  = 5'd7,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } ecode_t;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] PRID_VAL     = 32'h0000_4220;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    masked_write = (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// Count==Compare match and stays set until Compare is rewritten.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  output logic [31:0] count_q,
  output logic [31:0] compare_q,
  output logic        ti
);

  logic        toggle_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        ti_r;

  // Count, Compare, half-rate toggle and sticky timer interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_r  <= 1'b0;
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      toggle_r <= ~toggle_r;
      if (count_we) begin
        count_r <= count_wdata;
      end else if (toggle_r) begin
        count_r <= count_r + 32'd1;
      end
      if (compare_we) begin
        compare_r <= compare_wdata;
        ti_r      <= 1'b0;
      end else if (count_r == compare_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  assign count_q   = count_r;
  assign compare_q = compare_r;
  assign ti        = ti_r;

endmodule

// File: rtl/cp0.sv
// MIPS coprocessor 0: Status/Cause/EPC/BadVAddr, exception and eret commit
// with a registered PC redirect, mfc0 read port and interrupt masking.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_code,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  ext_int,
  output logic [7:0]  interrupt_info,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [31:0] status_r;
  logic [31:0] cause_r;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;

  logic        mtc0_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        ti_s;
  logic [31:0] rd_reg_s;
  logic [31:0] rd_fwd_s;

  // mtc0 only takes effect when neither an exception nor eret commits
  assign mtc0_s = we & ~ex_valid & ~eret;

  cp0_timer u_timer (
    .clk           (clk),
    .reset         (reset),
    .count_we      (mtc0_s && (waddr == REG_COUNT)),
    .count_wdata   (wdata),
    .compare_we    (mtc0_s && (waddr == REG_COMPARE)),
    .compare_wdata (wdata),
    .count_q       (count_s),
    .compare_q     (compare_s),
    .ti            (ti_s)
  );

  // Architectural register updates and redirect generation
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r         <= STATUS_RST;
      cause_r          <= 32'd0;
      epc_r            <= 32'd0;
      badvaddr_r       <= 32'd0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      redirect_valid_r <= 1'b0;
      if (ex_valid) begin
        if (!status_r[STATUS_EXL]) begin
          epc_r             <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
          cause_r[CAUSE_BD] <= ex_bd;
        end
        cause_r[6:2]          <= ex_code;
        status_r[STATUS_EXL]  <= 1'b1;
        if ((ex_code == EXC_ADEL) || (ex_code == EXC_ADES)) begin
          badvaddr_r <= ex_badvaddr;
        end
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= EXC_VECTOR;
      end else if (eret) begin
        status_r[STATUS_EXL] <= 1'b0;
        redirect_valid_r     <= 1'b1;
        redirect_pc_r        <= epc_r;
      end else if (mtc0_s) begin
        case (waddr)
          REG_STATUS: status_r <= masked_write(status_r, wdata, STATUS_WMASK);
          REG_CAUSE:  cause_r  <= masked_write(cause_r, wdata, CAUSE_WMASK);
          REG_EPC:    epc_r    <= wdata;
          default:    ;
        endcase
      end
      // hardware interrupt pending bits track the lines every cycle
      cause_r[15:10] <= {ext_int[5] | ti_s, ext_int[4:0]};
    end
  end

  // mfc0 read mux over registered state
  always_comb begin
    rd_reg_s = 32'd0;
    case (raddr)
      REG_BADVADDR: rd_reg_s = badvaddr_r;
      REG_COUNT:    rd_reg_s = count_s;
      REG_COMPARE:  rd_reg_s = compare_s;
      REG_STATUS:   rd_reg_s = status_r;
      REG_CAUSE:    rd_reg_s = cause_r;
      REG_EPC:      rd_reg_s = epc_r;
      REG_PRID:     rd_reg_s = PRID_VAL;
      default:      rd_reg_s = 32'd0;
    endcase
  end

  // Forward the masked value of a same-cycle write to the same index
  always_comb begin
    rd_fwd_s = rd_reg_s;
    if (we && (waddr == raddr)) begin
      case (waddr)
        REG_STATUS:  rd_fwd_s = masked_write(status_r, wdata, STATUS_WMASK);
        REG_CAUSE:   rd_fwd_s = masked_write(cause_r, wdata, CAUSE_WMASK);
        REG_EPC:     rd_fwd_s = wdata;
        REG_COUNT:   rd_fwd_s = wdata;
        REG_COMPARE: rd_fwd_s = wdata;
        default:     rd_fwd_s = rd_reg_s;
      endcase
    end else begin
      rd_fwd_s = rd_reg_s;
    end
  end

  assign rdata          = rd_fwd_s;
  assign interrupt_info = (status_r[STATUS_IE] & ~status_r[STATUS_EXL]) ?
                          (cause_r[15:8] & status_r[15:8]) : 8'h00;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: reset, timer interrupt, exception,
// nested exception, eret, priority, masks, forwarding and reset during commit.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_code;
  logic [31:0] ex_pc;
  logic        ex_bd;
  logic [31:0] ex_badvaddr;
  logic        eret;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  ext_int;
  logic [7:0]  interrupt_info;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  cp0 dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_code        (ex_code),
    .ex_pc          (ex_pc),
    .ex_bd          (ex_bd),
    .ex_badvaddr    (ex_badvaddr),
    .eret           (eret),
    .we             (we),
    .waddr          (waddr),
    .wdata          (wdata),
    .raddr          (raddr),
    .rdata          (rdata),
    .ext_int        (ext_int),
    .interrupt_info (interrupt_info),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    raddr = idx;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; ex_valid = 1'b0; ex_code = 5'd0; ex_pc = 32'd0; ex_bd = 1'b0;
    ex_badvaddr = 32'd0; eret = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    raddr = 5'd0; ext_int = 6'd0;
    step(); step();

    // reset values, still in reset
    read_chk("rst_status", 5'd12, 32'h0040_0000);
    read_chk("rst_cause", 5'd13, 32'h0000_0000);
    read_chk("rst_epc", 5'd14, 32'h0000_0000);
    read_chk("rst_count", 5'd9, 32'h0000_0000);
    check_eq("rst_intinfo", {24'd0, interrupt_info}, 32'h0000_0000);
    check_eq("rst_redir", {31'd0, redirect_valid}, 32'h0000_0000);

    // timer: Compare=4, then Status=0x8001 (checked through write forwarding)
    reset = 1'b0; we = 1'b1; waddr = 5'd11; wdata = 32'd4;
    step();
    waddr = 5'd12; wdata = 32'h0000_8001;
    read_chk("fwd_status", 5'd12, 32'h0040_8001);
    step();
    we = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      raddr = 5'd13;
      #1;
      if (rdata[15]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq("ti_rise", {31'd0, found}, 32'd1);
    check_eq("ti_intinfo", {24'd0, interrupt_info}, 32'h0000_0080);

    // rewriting Compare clears TI
    we = 1'b1; waddr = 5'd11; wdata = 32'hFFFF_0000;
    step();
    we = 1'b0;
    step();
    raddr = 5'd13; #1;
    check_eq("ti_clear", {31'd0, rdata[15]}, 32'd0);
    check_eq("ti_clear_int", {24'd0, interrupt_info}, 32'h0000_0000);

    // Count write, read-only PRId, unimplemented index
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0010;
    step();
    we = 1'b0;
    read_chk("count_wr", 5'd9, 32'h0000_0010);
    read_chk("prid", 5'd15, 32'h0000_4220);
    we = 1'b1; waddr = 5'd15; wdata = 32'h0;
    step();
    we = 1'b0;
    read_chk("prid_ro", 5'd15, 32'h0000_4220);
    read_chk("idx0", 5'd0, 32'h0000_0000);

    // exception in delay slot, ADEL
    ex_valid = 1'b1; ex_code = 5'd4; ex_pc = 32'hBFC0_0100; ex_bd = 1'b1; ex_badvaddr = 32'h0000_1001;
    step();
    ex_valid = 1'b0;
    check_eq("exc_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("exc_rpc", redirect_pc, 32'hBFC0_0380);
    read_chk("exc_epc", 5'd14, 32'hBFC0_00FC);
    read_chk("exc_cause", 5'd13, 32'h8000_0010);
    read_chk("exc_badv", 5'd8, 32'h0000_1001);
    read_chk("exc_status", 5'd12, 32'h0040_8003);
    step();
    check_eq("exc_pulse", {31'd0, redirect_valid}, 32'd0);

    // nested SYS with EXL=1
    ex_valid = 1'b1; ex_code = 5'd8; ex_pc = 32'h0000_0200; ex_bd = 1'b0; ex_badvaddr = 32'h0000_5555;
    step();
    ex_valid = 1'b0;
    check_eq("nest_rv", {31'd0, redirect_valid}, 32'd1);
    read_chk("nest_epc", 5'd14, 32'hBFC0_00FC);
    read_chk("nest_cause", 5'd13, 32'h8000_0020);
    read_chk("nest_badv", 5'd8, 32'h0000_1001);

    // eret with a competing mtc0 to EPC (dropped)
    eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234;
    step();
    eret = 1'b0; we = 1'b0;
    check_eq("eret_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("eret_rpc", redirect_pc, 32'hBFC0_00FC);
    read_chk("eret_status", 5'd12, 32'h0040_8001);
    read_chk("eret_epc", 5'd14, 32'hBFC0_00FC);

    // exception and mtc0 to EPC in the same cycle
    ex_valid = 1'b1; ex_code = 5'd9; ex_pc = 32'h0000_0300; ex_bd = 1'b0;
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    step();
    ex_valid = 1'b0; we = 1'b0;
    read_chk("prio_epc", 5'd14, 32'h0000_0300);
    read_chk("prio_cause", 5'd13, 32'h0000_0024);
    check_eq("prio_rpc", redirect_pc, 32'hBFC0_0380);

    // Cause write mask and external line sampling, masked by EXL
    we = 1'b1; waddr = 5'd13; wdata = 32'hFFFF_FFFF; ext_int = 6'b000001;
    step();
    we = 1'b0;
    step();
    read_chk("cause_mask", 5'd13, 32'h0000_0724);
    check_eq("exl_mask", {24'd0, interrupt_info}, 32'h0000_0000);
    eret = 1'b1;
    step();
    eret = 1'b0;
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF01;
    step();
    we = 1'b0;
    check_eq("im_all", {24'd0, interrupt_info}, 32'h0000_0007);

    // reset asserted together with an exception commit
    reset = 1'b1; ex_valid = 1'b1; ex_code = 5'd4; ex_badvaddr = 32'h0000_7777;
    step();
    ex_valid = 1'b0;
    check_eq("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
    read_chk("rst_mid_status", 5'd12, 32'h0040_0000);
    read_chk("rst_mid_badv", 5'd8, 32'h0000_0000);
    read_chk("rst_mid_epc", 5'd14, 32'h0000_0000);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
